pcm_pingpong_buffer: RTL

PCM_PINGPONG_BUFFER -- requirements
Module: pcm_pingpong_buffer

---
 rtl/pcm_pingpong_buffer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pcm_pingpong_buffer.sv
// Ping-pong PCM sample buffer: the audio receiver fills one bank while the consumer drains
// the other. Banks alternate strictly, so samples leave in arrival order. Samples arriving
// while the writer's bank is still full are dropped and counted.
module pcm_pingpong_buffer #(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned DATA_W = 24
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              wr_valid_i,
   output logic [DATA_W-1:0] ram_read_data_o,
   output logic              ram_read_valid_o,
   input  logic              ram_read_ready_i,
   output logic              ram_buffer_ready_o,
   output logic              overflow_o,
   output logic [15:0]       drop_count_o,
   output logic [1:0]        rd_state_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StPrime  = 2'd1,
      StStream = 2'd2,
      StFlush  = 2'd3
   } rd_state_e;

   logic [1:0]        rst_sync_q;
   logic              rst_n;
   logic [DATA_W-1:0] mem_q [2*DEPTH];
   logic [1:0]        full_q, full_d;
   logic              wr_bank_q;
   logic [AW-1:0]     wr_count_q;
   logic              buf_ready_q;
   logic              overflow_q;
   logic [15:0]       drop_count_q;
   logic              rd_bank_q;
   logic [AW-1:0]     rd_idx_q, rd_idx_nxt;
   logic [AW:0]       rd_addr;
   logic [DATA_W-1:0] rd_data_q;
   rd_state_e         state_q, state_d;
   logic              wr_en, wr_last, wr_drop;
   logic              rd_hs, rd_last, load_first;

   // Reset asserts asynchronously but releases only on a clock edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rst_sync_q <= 2'b00;
      else         rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   // Writer decisions use the registered full flags only.
   assign wr_en   = wr_valid_i & ~full_q[wr_bank_q];
   assign wr_drop = wr_valid_i &  full_q[wr_bank_q];
   assign wr_last = wr_en & (wr_count_q == AW'(DEPTH - 1));

   // Reader handshake; valid exists only in STREAM.
   assign rd_hs      = (state_q == StStream) & ram_read_ready_i;
   assign rd_last    = rd_hs & (rd_idx_q == AW'(DEPTH - 1));
   assign rd_idx_nxt = rd_idx_q + 1'b1;

   // Full flags: writer sets its bank, reader clears its bank; never the same bank at once.
   always_comb begin
      full_d = full_q;
      if (wr_last) full_d[wr_bank_q] = 1'b1;
      if (rd_last) full_d[rd_bank_q] = 1'b0;
   end

   // Sample storage; no reset, contents are discarded logically by clearing the flags.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[{wr_bank_q, wr_count_q}] <= wr_data_i;
   end

   // Writer pointer, fill pulse and drop accounting.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         full_q       <= 2'b00;
         wr_bank_q    <= 1'b0;
         wr_count_q   <= '0;
         buf_ready_q  <= 1'b0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         full_q      <= full_d;
         buf_ready_q <= wr_last;
         if (wr_en) begin
            if (wr_last) begin
               wr_count_q <= '0;
               wr_bank_q  <= ~wr_bank_q;
            end else begin
               wr_count_q <= wr_count_q + 1'b1;
            end
         end
         if (wr_drop) begin
            overflow_q <= 1'b1;
            if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
         end
      end
   end

   // Reader state register.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Reader next state; PRIME covers the RAM read latency of index 0.
   always_comb begin
      state_d    = state_q;
      load_first = 1'b0;
      unique case (state_q)
         StIdle:   if (full_q[rd_bank_q]) state_d = StPrime;
         StPrime: begin
            state_d    = StStream;
            load_first = 1'b1;
         end
         StStream: if (rd_last) state_d = StFlush;
         StFlush:  state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Read address: index 0 when priming, otherwise the sample after the one presented.
   always_comb begin
      rd_addr = {rd_bank_q, rd_idx_nxt};
      if (load_first) rd_addr = {rd_bank_q, {AW{1'b0}}};
   end

   // Output register reloads only on prime or handshake, so data holds while stalled.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         rd_bank_q <= 1'b0;
         rd_idx_q  <= '0;
         rd_data_q <= '0;
      end else if (load_first) begin
         rd_data_q <= mem_q[rd_addr];
         rd_idx_q  <= '0;
      end else if (rd_hs) begin
         if (rd_last) begin
            rd_bank_q <= ~rd_bank_q;
         end else begin
            rd_data_q <= mem_q[rd_addr];
            rd_idx_q  <= rd_idx_nxt;
         end
      end
   end

   assign ram_read_data_o    = rd_data_q;
   assign ram_read_valid_o   = (state_q == StStream);
   assign ram_buffer_ready_o = buf_ready_q;
   assign overflow_o         = overflow_q;
   assign drop_count_o       = drop_count_q;
   assign rd_state_o         = state_q;

endmodule
